// File: rtl/mem_pkg.sv
// Shared widths and tag types for the mapper memory responder.
package mem_pkg;

  localparam int MEM_ADDR_W = 24;
  localparam int MEM_DATA_W = 16;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_PPU = 1'b1
  } mem_src_t;

  typedef struct packed {
    logic     rd;
    mem_src_t src;
  } mem_tag_t;

endpackage

// File: rtl/mem_responder_if.sv
// Requester ports (CPU and PPU) plus the RAM command/data port of the responder.
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W
);

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_req;
  logic              mem_wr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_out;
  logic              mem_valid;

  logic [ADDR_W-1:0] mem_ppu_addr;
  logic [DATA_W-1:0] mem_ppu_data;
  logic              mem_ppu_req;
  logic              mem_ppu_wr;
  logic              mem_ppu_ack;
  logic [DATA_W-1:0] mem_ppu_out;
  logic              mem_ppu_valid;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  mem_addr, mem_data, mem_req, mem_wr,
    input  mem_ppu_addr, mem_ppu_data, mem_ppu_req, mem_ppu_wr,
    input  ram_rdata,
    output mem_ack, mem_out, mem_valid,
    output mem_ppu_ack, mem_ppu_out, mem_ppu_valid,
    output ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output mem_addr, mem_data, mem_req, mem_wr,
    output mem_ppu_addr, mem_ppu_data, mem_ppu_req, mem_ppu_wr,
    output ram_rdata,
    input  mem_ack, mem_out, mem_valid,
    input  mem_ppu_ack, mem_ppu_out, mem_ppu_valid,
    input  ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_rd_tag_pipe.sv
// Tag delay line: the tag pushed in a command cycle appears on tag_out READ_LAT cycles later,
// aligned with ram_rdata. Advances every cycle, so it never backpressures.
module mem_rd_tag_pipe
  import mem_pkg::*;
#(
  parameter int READ_LAT = 2
) (
  input  logic     clkRAM,
  input  logic     n_reset,
  input  mem_tag_t push_tag,
  output mem_tag_t tag_out
);

  mem_tag_t pipe_q [READ_LAT];
  mem_tag_t pipe_d [READ_LAT];

  always_comb begin
    pipe_d[0] = push_tag;
    for (int i = 1; i < READ_LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clkRAM) begin
    if (!n_reset) begin
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_out = pipe_q[READ_LAT-1];

endmodule

// File: rtl/mem_responder.sv
// Round-robin arbiter of CPU/PPU requests onto one RAM port; ack one cycle after the request is seen,
// read data valid READ_LAT+1 cycles after the ack. Requesters are held off by withholding ack.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W   = MEM_ADDR_W,
  parameter int DATA_W   = MEM_DATA_W,
  parameter int READ_LAT = 2
) (
  input  logic           clkRAM,
  input  logic           n_reset,
  mem_responder_if.slave bus
);

  logic              ack_c_q, ack_c_d;
  logic              ack_p_q, ack_p_d;
  logic              ram_en_q, ram_en_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  mem_src_t          last_q, last_d;
  logic              vld_c_q, vld_c_d;
  logic              vld_p_q, vld_p_d;
  logic [DATA_W-1:0] out_c_q, out_c_d;
  logic [DATA_W-1:0] out_p_q, out_p_d;

  logic              elig_c, elig_p, gnt_vld;
  mem_src_t          gnt_src;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  mem_tag_t          push_tag, ret_tag;

  // A request still held during its own ack cycle must not win a second grant.
  assign elig_c  = bus.mem_req     && !ack_c_q;
  assign elig_p  = bus.mem_ppu_req && !ack_p_q;
  assign gnt_vld = elig_c || elig_p;

  always_comb begin
    if (elig_c && elig_p) begin
      gnt_src = (last_q == SRC_CPU) ? SRC_PPU : SRC_CPU;
    end else if (elig_p) begin
      gnt_src = SRC_PPU;
    end else begin
      gnt_src = SRC_CPU;
    end
  end

  assign sel_wr   = (gnt_src == SRC_PPU) ? bus.mem_ppu_wr   : bus.mem_wr;
  assign sel_addr = (gnt_src == SRC_PPU) ? bus.mem_ppu_addr : bus.mem_addr;
  assign sel_data = (gnt_src == SRC_PPU) ? bus.mem_ppu_data : bus.mem_data;

  always_comb begin
    ack_c_d     = gnt_vld && (gnt_src == SRC_CPU);
    ack_p_d     = gnt_vld && (gnt_src == SRC_PPU);
    ram_en_d    = gnt_vld;
    ram_we_d    = gnt_vld && sel_wr;
    ram_addr_d  = gnt_vld ? sel_addr : ram_addr_q;
    ram_wdata_d = gnt_vld ? sel_data : ram_wdata_q;
    last_d      = gnt_vld ? gnt_src : last_q;
  end

  // The command cycle is identified by the registered ack, so the tag source follows it.
  always_comb begin
    push_tag.rd  = ram_en_q && !ram_we_q;
    push_tag.src = ack_p_q ? SRC_PPU : SRC_CPU;
  end

  mem_rd_tag_pipe #(
    .READ_LAT (READ_LAT)
  ) u_tag_pipe (
    .clkRAM   (clkRAM),
    .n_reset  (n_reset),
    .push_tag (push_tag),
    .tag_out  (ret_tag)
  );

  always_comb begin
    vld_c_d = ret_tag.rd && (ret_tag.src == SRC_CPU);
    vld_p_d = ret_tag.rd && (ret_tag.src == SRC_PPU);
    out_c_d = vld_c_d ? bus.ram_rdata : out_c_q;
    out_p_d = vld_p_d ? bus.ram_rdata : out_p_q;
  end

  always_ff @(posedge clkRAM) begin
    if (!n_reset) begin
      ack_c_q     <= 1'b0;
      ack_p_q     <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      last_q      <= SRC_CPU;
      vld_c_q     <= 1'b0;
      vld_p_q     <= 1'b0;
      out_c_q     <= '0;
      out_p_q     <= '0;
    end else begin
      ack_c_q     <= ack_c_d;
      ack_p_q     <= ack_p_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      last_q      <= last_d;
      vld_c_q     <= vld_c_d;
      vld_p_q     <= vld_p_d;
      out_c_q     <= out_c_d;
      out_p_q     <= out_p_d;
    end
  end

  assign bus.mem_ack       = ack_c_q;
  assign bus.mem_ppu_ack   = ack_p_q;
  assign bus.mem_valid     = vld_c_q;
  assign bus.mem_ppu_valid = vld_p_q;
  assign bus.mem_out       = out_c_q;
  assign bus.mem_ppu_out   = out_p_q;
  assign bus.ram_en        = ram_en_q;
  assign bus.ram_we        = ram_we_q;
  assign bus.ram_addr      = ram_addr_q;
  assign bus.ram_wdata     = ram_wdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Drives identical requester traffic into a READ_LAT=2 and a READ_LAT=5 responder and checks every
// output, every cycle, against a transaction-level model of grants, RAM contents and return timing.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int NCYC = 1600;
  localparam int LAT0 = 2;
  localparam int LAT1 = 5;
  localparam int SCH  = NCYC + 16;

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDR_W(MEM_ADDR_W), .DATA_W(MEM_DATA_W)) if0 ();
  mem_responder_if #(.ADDR_W(MEM_ADDR_W), .DATA_W(MEM_DATA_W)) if1 ();

  mem_responder #(.ADDR_W(MEM_ADDR_W), .DATA_W(MEM_DATA_W), .READ_LAT(LAT0)) dut0 (
    .clkRAM (clk), .n_reset (n_reset), .bus (if0)
  );
  mem_responder #(.ADDR_W(MEM_ADDR_W), .DATA_W(MEM_DATA_W), .READ_LAT(LAT1)) dut1 (
    .clkRAM (clk), .n_reset (n_reset), .bus (if1)
  );

  typedef struct {
    bit          wr;
    logic [23:0] addr;
    logic [15:0] data;
    bit          hold;
  } req_t;

  typedef struct {
    logic        ack_c, ack_p, en, we, vld_c, vld_p;
    logic [23:0] addr;
    logic [15:0] wdata, out_c, out_p;
  } obs_t;

  int n_chk = 0;
  int n_err = 0;
  int cur_cyc = 0;

  // requester state and pins
  req_t        q_c[$], q_p[$];
  bit          act [2];
  req_t        cur [2];
  logic        p_req [2];
  logic        p_wr [2];
  logic [23:0] p_addr [2];
  logic [15:0] p_data [2];

  // RAM environment models, one per DUT
  logic [15:0] ram_m0 [int];
  logic [15:0] ram_m1 [int];
  bit          r_v [2][SCH];
  logic [15:0] r_d [2][SCH];

  // reference model
  logic [15:0] ref_m [int];
  bit          s_v [2][SCH];
  bit          s_p [2][SCH];
  logic [15:0] s_d [2][SCH];
  bit          e_ack [2];
  bit          e_en, e_we;
  logic [23:0] e_addr;
  logic [15:0] e_wdata;
  bit          e_vld [2][2];
  logic [15:0] e_out [2][2];
  int          last_g = 0;

  obs_t ob [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cur_cyc, got, exp);
    end
  endtask

  function automatic logic [15:0] dflt(input logic [23:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  task automatic sample(input int cyc);
    int k;
    ob[0].ack_c = if0.mem_ack;    ob[0].ack_p = if0.mem_ppu_ack;
    ob[0].en    = if0.ram_en;     ob[0].we    = if0.ram_we;
    ob[0].vld_c = if0.mem_valid;  ob[0].vld_p = if0.mem_ppu_valid;
    ob[0].addr  = if0.ram_addr;   ob[0].wdata = if0.ram_wdata;
    ob[0].out_c = if0.mem_out;    ob[0].out_p = if0.mem_ppu_out;
    ob[1].ack_c = if1.mem_ack;    ob[1].ack_p = if1.mem_ppu_ack;
    ob[1].en    = if1.ram_en;     ob[1].we    = if1.ram_we;
    ob[1].vld_c = if1.mem_valid;  ob[1].vld_p = if1.mem_ppu_valid;
    ob[1].addr  = if1.ram_addr;   ob[1].wdata = if1.ram_wdata;
    ob[1].out_c = if1.mem_out;    ob[1].out_p = if1.mem_ppu_out;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d.mem_ack", d),       32'(ob[d].ack_c), 32'(e_ack[0]));
      chk($sformatf("d%0d.mem_ppu_ack", d),   32'(ob[d].ack_p), 32'(e_ack[1]));
      chk($sformatf("d%0d.ram_en", d),        32'(ob[d].en),    32'(e_en));
      chk($sformatf("d%0d.ram_we", d),        32'(ob[d].we),    32'(e_we));
      chk($sformatf("d%0d.ram_addr", d),      32'(ob[d].addr),  32'(e_addr));
      chk($sformatf("d%0d.ram_wdata", d),     32'(ob[d].wdata), 32'(e_wdata));
      chk($sformatf("d%0d.mem_valid", d),     32'(ob[d].vld_c), 32'(e_vld[d][0]));
      chk($sformatf("d%0d.mem_ppu_valid", d), 32'(ob[d].vld_p), 32'(e_vld[d][1]));
      chk($sformatf("d%0d.mem_out", d),       32'(ob[d].out_c), 32'(e_out[d][0]));
      chk($sformatf("d%0d.mem_ppu_out", d),   32'(ob[d].out_p), 32'(e_out[d][1]));
    end
    // the RAM reads at command time and presents the word LAT cycles later
    if (ob[0].en === 1'b1) begin
      k = int'(ob[0].addr);
      r_v[0][cyc+LAT0] = 1'b1;
      r_d[0][cyc+LAT0] = ram_m0.exists(k) ? ram_m0[k] : dflt(ob[0].addr);
      if (ob[0].we === 1'b1) ram_m0[k] = ob[0].wdata;
    end
    if (ob[1].en === 1'b1) begin
      k = int'(ob[1].addr);
      r_v[1][cyc+LAT1] = 1'b1;
      r_d[1][cyc+LAT1] = ram_m1.exists(k) ? ram_m1[k] : dflt(ob[1].addr);
      if (ob[1].we === 1'b1) ram_m1[k] = ob[1].wdata;
    end
  endtask

  task automatic push_req(input int p, input bit wr, input logic [23:0] addr,
                          input logic [15:0] data, input bit hold);
    req_t r;
    r.wr = wr; r.addr = addr; r.data = data; r.hold = hold;
    if (p == 0) q_c.push_back(r);
    else        q_p.push_back(r);
  endtask

  task automatic requester(input int p, input logic seen_ack);
    int qs;
    qs = (p == 0) ? q_c.size() : q_p.size();
    if (act[p] && seen_ack === 1'b1) begin
      act[p] = 1'b0;
      if (!cur[p].hold) p_req[p] = 1'b0;
    end else if (!act[p]) begin
      if (qs > 0) begin
        if (p == 0) cur[p] = q_c.pop_front();
        else        cur[p] = q_p.pop_front();
        act[p]    = 1'b1;
        p_req[p]  = 1'b1;
        p_wr[p]   = cur[p].wr;
        p_addr[p] = cur[p].addr;
        p_data[p] = cur[p].data;
      end else begin
        p_req[p] = 1'b0;
      end
    end
  endtask

  task automatic apply_pins(input int cyc);
    if0.mem_req = p_req[0];     if1.mem_req = p_req[0];
    if0.mem_wr = p_wr[0];       if1.mem_wr = p_wr[0];
    if0.mem_addr = p_addr[0];   if1.mem_addr = p_addr[0];
    if0.mem_data = p_data[0];   if1.mem_data = p_data[0];
    if0.mem_ppu_req = p_req[1];   if1.mem_ppu_req = p_req[1];
    if0.mem_ppu_wr = p_wr[1];     if1.mem_ppu_wr = p_wr[1];
    if0.mem_ppu_addr = p_addr[1]; if1.mem_ppu_addr = p_addr[1];
    if0.mem_ppu_data = p_data[1]; if1.mem_ppu_data = p_data[1];
    // off-slot cycles carry junk so a mistimed capture shows up
    if0.ram_rdata = r_v[0][cyc] ? r_d[0][cyc] : 16'($urandom);
    if1.ram_rdata = r_v[1][cyc] ? r_d[1][cyc] : 16'($urandom);
  endtask

  task automatic drive(input int cyc);
    bit rnd_rst;
    rnd_rst = (cyc >= 60) && (cyc < NCYC - 30) && ($urandom_range(0, 199) == 0);
    n_reset = !((cyc < 3) || (cyc == 20) || (cyc == 42) || rnd_rst);
    if (cyc == 3)  push_req(0, 1'b0, 24'h000123, 16'h0000, 1'b0);
    if (cyc == 12) push_req(1, 1'b1, 24'h002000, 16'h00A5, 1'b0);
    if (cyc == 22) begin
      for (int i = 0; i < 3; i++) begin
        push_req(0, 1'b0, 24'(16 + i), 16'h0000, 1'b1);
        push_req(1, 1'b0, 24'(32 + i), 16'h0000, 1'b1);
      end
    end
    if (cyc == 40) push_req(0, 1'b0, 24'h000777, 16'h0000, 1'b0);
    if (cyc >= 50 && cyc < NCYC - 30) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && ((p == 0) ? q_c.size() : q_p.size()) == 0 && $urandom_range(0, 2) == 0)
          push_req(p, $urandom_range(0, 2) == 0, 24'($urandom_range(0, 15)),
                   16'($urandom), 1'($urandom_range(0, 1)));
      end
    end
    requester(0, ob[0].ack_c);
    requester(1, ob[0].ack_p);
    apply_pins(cyc);
  endtask

  // Predicts all outputs of cycle cyc+1 from the pins of cycle cyc.
  task automatic model_step(input int cyc);
    bit el_c, el_p;
    int g, k;
    logic [15:0] rd;
    if (!n_reset) begin
      e_ack[0] = 1'b0; e_ack[1] = 1'b0;
      e_en = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0;
      last_g = 0;
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          e_vld[d][p] = 1'b0;
          e_out[d][p] = '0;
        end
        for (int i = cyc + 1; i < SCH; i++) s_v[d][i] = 1'b0;
      end
    end else begin
      el_c = p_req[0] && !e_ack[0];
      el_p = p_req[1] && !e_ack[1];
      g = -1;
      if (el_c && el_p) g = 1 - last_g;
      else if (el_c)    g = 0;
      else if (el_p)    g = 1;
      e_ack[0] = (g == 0);
      e_ack[1] = (g == 1);
      e_en = (g >= 0);
      e_we = 1'b0;
      if (g >= 0) begin
        e_we    = p_wr[g];
        e_addr  = p_addr[g];
        e_wdata = p_data[g];
        last_g  = g;
        k = int'(p_addr[g]);
        if (p_wr[g]) begin
          ref_m[k] = p_data[g];
        end else begin
          rd = ref_m.exists(k) ? ref_m[k] : dflt(p_addr[g]);
          s_v[0][cyc+2+LAT0] = 1'b1; s_p[0][cyc+2+LAT0] = 1'(g); s_d[0][cyc+2+LAT0] = rd;
          s_v[1][cyc+2+LAT1] = 1'b1; s_p[1][cyc+2+LAT1] = 1'(g); s_d[1][cyc+2+LAT1] = rd;
        end
      end
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          e_vld[d][p] = s_v[d][cyc+1] && (int'(s_p[d][cyc+1]) == p);
          if (e_vld[d][p]) e_out[d][p] = s_d[d][cyc+1];
        end
      end
    end
  endtask

  initial begin
    n_reset = 1'b0;
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; p_req[p] = 1'b0; p_wr[p] = 1'b0; p_addr[p] = '0; p_data[p] = '0;
    end
    ram_m0[32'h123] = 16'hBEEF;
    ram_m1[32'h123] = 16'hBEEF;
    ref_m[32'h123]  = 16'hBEEF;
    apply_pins(0);
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cur_cyc = c;
      sample(c);
      drive(c);
      model_step(c);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
